// File: rtl/axi_str_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter: width defaults, FSM state type
// and the source-index width helper.
package axi_str_pkg;

   localparam int unsigned DATA_SIZE_DEF = 32;
   localparam int unsigned USER_SIZE_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   // Never returns 0 so index vectors stay legal even for a single source.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping
// modulo NUM_SRC.
module rr_arbiter #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid
);

   int unsigned idx;

   always_comb begin
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         idx = (32'(ptr) + k) % NUM_SRC;
         if (!gnt_valid && req[IDX_W'(idx)]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/axi_str_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream slaves onto one master;
// the grant is locked from arbitration until the granted source's tlast beat.
module axi_str_arbiter
   import axi_str_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
   parameter int unsigned USER_SIZE = USER_SIZE_DEF,
   localparam int unsigned IDX_W    = idx_width(NUM_SRC),
   localparam int unsigned KEEP_W   = DATA_SIZE / 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_SRC-1:0]           s_tvalid,
   output logic [NUM_SRC-1:0]           s_tready,
   input  logic [NUM_SRC*DATA_SIZE-1:0] s_tdata,
   input  logic [NUM_SRC*KEEP_W-1:0]    s_tkeep,
   input  logic [NUM_SRC*USER_SIZE-1:0] s_tuser,
   input  logic [NUM_SRC-1:0]           s_tlast,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [DATA_SIZE-1:0]         m_tdata,
   output logic [KEEP_W-1:0]            m_tkeep,
   output logic [USER_SIZE-1:0]         m_tuser,
   output logic                         m_tlast,
   output logic [IDX_W-1:0]             m_tid,
   output logic                         busy
);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_valid;
   logic             in_xfer;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req       (s_tvalid),
      .ptr       (ptr_q),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign in_xfer = (state_q == XFER);

   // Zero-latency datapath: the payload simply follows the held grant index.
   always_comb begin
      m_tdata  = s_tdata[32'(gnt_q)*DATA_SIZE +: DATA_SIZE];
      m_tkeep  = s_tkeep[32'(gnt_q)*KEEP_W +: KEEP_W];
      m_tuser  = s_tuser[32'(gnt_q)*USER_SIZE +: USER_SIZE];
      m_tlast  = s_tlast[gnt_q];
      m_tvalid = in_xfer && s_tvalid[gnt_q];
      m_tid    = gnt_q;
      busy     = in_xfer;
      s_tready = '0;
      if (in_xfer) begin
         s_tready[gnt_q] = m_tready;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               gnt_d   = arb_idx;
               state_d = XFER;
            end
         end
         XFER: begin
            if (m_tvalid && m_tready && m_tlast) begin
               state_d = IDLE;
               ptr_d   = (gnt_q == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_q + 1'b1;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_axi_str_arbiter.sv
// Randomized and directed bench for axi_str_arbiter against a queue-based packet model.
module tb_axi_str_arbiter;

   localparam int N = 4;
   localparam int D = 32;
   localparam int U = 16;
   localparam int K = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   s_tvalid, s_tready, s_tlast;
   logic [N*D-1:0] s_tdata;
   logic [N*K-1:0] s_tkeep;
   logic [N*U-1:0] s_tuser;
   logic           m_tvalid, m_tready, m_tlast, busy;
   logic [D-1:0]   m_tdata;
   logic [K-1:0]   m_tkeep;
   logic [U-1:0]   m_tuser;
   logic [1:0]     m_tid;

   axi_str_arbiter #(
      .NUM_SRC   (N),
      .DATA_SIZE (D),
      .USER_SIZE (U)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .s_tdata  (s_tdata),
      .s_tkeep  (s_tkeep),
      .s_tuser  (s_tuser),
      .s_tlast  (s_tlast),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tdata  (m_tdata),
      .m_tkeep  (m_tkeep),
      .m_tuser  (m_tuser),
      .m_tlast  (m_tlast),
      .m_tid    (m_tid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [D-1:0] data;
      logic [K-1:0] keep;
      logic [U-1:0] user;
      logic         last;
   } beat_t;

   typedef struct {
      int           tid;
      logic [D-1:0] data;
      logic         last;
      int           cyc;
   } xfer_t;

   beat_t src_q[N][$];
   xfer_t xlog[$];
   bit    tr_pat[$];
   bit    rnd = 1'b0;
   int    n_cmp = 0;
   int    n_err = 0;
   int    cyc = 0;
   // Model state: packet in flight, its source, round-robin start point.
   bit    mb;
   int    mg, mp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_beat(input string name, input int k, input int tid, input logic [D-1:0] data);
      if (k >= xlog.size()) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: beat %0d never transferred (got %0d beats)", name, k, xlog.size());
      end else begin
         chk({name, "_tid"}, 64'(xlog[k].tid), 64'(tid));
         chk({name, "_data"}, 64'(xlog[k].data), 64'(data));
      end
   endtask

   task automatic chk_gap(input string name, input int k, input int gap);
      if (k >= xlog.size() || k < 1) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: beat %0d missing, got %0d beats, want gap %0d", name, k, xlog.size(), gap);
      end else begin
         chk(name, 64'(xlog[k].cyc - xlog[k-1].cyc), 64'(gap));
      end
   endtask

   task automatic push_pkt(input int s, input int len, input logic [D-1:0] base);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = base + D'(i);
         b.keep = rnd ? K'($urandom) : 4'hF;
         b.user = rnd ? U'($urandom) : U'(s * 256 + i);
         b.last = (i == len - 1);
         src_q[s].push_back(b);
      end
   endtask

   task automatic wait_log(input int n, input int budget, input string name);
      int t = 0;
      while (xlog.size() < n && t < budget) begin
         @(posedge clk);
         t++;
      end
      chk({name, "_beats_seen"}, 64'(xlog.size() >= n), 64'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 reset = 1'b1;
      for (int i = 0; i < N; i++) src_q[i].delete();
      tr_pat.delete();
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      xlog.delete();
   endtask

   // Source drivers: present the head of each queue just after the clock edge.
   initial begin
      s_tvalid = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tuser  = '0;
      s_tlast  = '0;
      m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
               s_tvalid[i]       = !rnd || ($urandom_range(3) != 0);
               s_tdata[i*D +: D] = src_q[i][0].data;
               s_tkeep[i*K +: K] = src_q[i][0].keep;
               s_tuser[i*U +: U] = src_q[i][0].user;
               s_tlast[i]        = src_q[i][0].last;
            end else begin
               s_tvalid[i]       = 1'b0;
               s_tdata[i*D +: D] = D'($urandom);
               s_tlast[i]        = 1'(($urandom));
            end
         end
         if (tr_pat.size() > 0) m_tready = tr_pat.pop_front();
         else m_tready = rnd ? ($urandom_range(2) != 0) : 1'b1;
      end
   end

   // Compare process: checks DUT against the packet model every cycle, then advances it.
   initial begin : compare
      logic [N-1:0] er;
      logic         ev;
      beat_t        h;
      bit           found;
      mb = 1'b0;
      mg = 0;
      mp = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
            chk("rst_s_tready", 64'(s_tready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_m_tid", 64'(m_tid), 64'd0);
            mb = 1'b0;
            mg = 0;
            mp = 0;
         end else begin
            ev = mb && s_tvalid[mg];
            er = '0;
            if (mb && m_tready) er[mg] = 1'b1;
            chk("m_tvalid", 64'(m_tvalid), 64'(ev));
            chk("s_tready", 64'(s_tready), 64'(er));
            chk("busy", 64'(busy), 64'(mb));
            if (ev) begin
               h = src_q[mg][0];
               chk("m_tid", 64'(m_tid), 64'(mg));
               chk("m_tdata", 64'(m_tdata), 64'(h.data));
               chk("m_tkeep", 64'(m_tkeep), 64'(h.keep));
               chk("m_tuser", 64'(m_tuser), 64'(h.user));
               chk("m_tlast", 64'(m_tlast), 64'(h.last));
            end
            if (m_tvalid && m_tready) xlog.push_back('{int'(m_tid), m_tdata, m_tlast, cyc});
            if (!mb) begin
               found = 1'b0;
               for (int k = 0; k < N; k++) begin
                  if (!found && s_tvalid[(mp + k) % N]) begin
                     found = 1'b1;
                     mb    = 1'b1;
                     mg    = (mp + k) % N;
                  end
               end
            end else if (ev && m_tready) begin
               h = src_q[mg].pop_front();
               if (h.last) begin
                  mb = 1'b0;
                  mp = (mg + 1) % N;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int ord[5];
      int base;
      int drained;
      ord = '{0, 1, 2, 3, 0};

      // Single 3-beat packet from src2, then src0/src3 contend with the pointer at 3.
      do_reset();
      push_pkt(2, 3, 32'hA0);
      wait_log(3, 20, "s1");
      chk_beat("s1_b0", 0, 2, 32'hA0);
      chk_beat("s1_b1", 1, 2, 32'hA1);
      chk_beat("s1_b2", 2, 2, 32'hA2);
      repeat (3) @(posedge clk);
      chk("s1_model_ptr", 64'(mp), 64'd3);
      push_pkt(0, 1, 32'hB0);
      push_pkt(3, 1, 32'hB3);
      wait_log(5, 20, "s1b");
      chk_beat("s1_ptr3_first", 3, 3, 32'hB3);
      chk_beat("s1_wrap_next", 4, 0, 32'hB0);

      // All sources continuously requesting 2-beat packets.
      do_reset();
      for (int s = 0; s < N; s++) push_pkt(s, 2, D'((s << 8) | 0));
      push_pkt(0, 2, 32'h010);
      wait_log(10, 60, "s2");
      for (int p = 0; p < 5; p++) begin
         base = (ord[p] << 8) | ((p == 4) ? 16 : 0);
         chk_beat("s2_order", 2 * p, ord[p], D'(base));
         chk_gap("s2_in_pkt_gap", 2 * p + 1, 1);
         if (p > 0) chk_gap("s2_idle_gap", 2 * p, 2);
      end

      // src0 arrives while src1 is mid-packet.
      do_reset();
      push_pkt(1, 4, 32'h300);
      wait_log(1, 20, "s3a");
      push_pkt(0, 1, 32'h3F0);
      wait_log(5, 40, "s3");
      for (int i = 0; i < 4; i++) chk_beat("s3_src1", i, 1, D'(32'h300 + i));
      chk_beat("s3_src0", 4, 0, 32'h3F0);
      chk_gap("s3_src0_gap", 4, 2);

      // Backpressure during a 4-beat packet.
      do_reset();
      tr_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      push_pkt(2, 4, 32'h400);
      wait_log(4, 30, "s4");
      repeat (5) @(posedge clk);
      chk("s4_count", 64'(xlog.size()), 64'd4);
      for (int i = 0; i < 4; i++) chk_beat("s4_beat", i, 2, D'(32'h400 + i));

      // Reset mid-packet from src3 with the pointer at 3; src1 then wins from pointer 0.
      do_reset();
      push_pkt(2, 1, 32'h500);
      wait_log(1, 20, "s5a");
      push_pkt(3, 5, 32'h530);
      wait_log(3, 30, "s5b");
      #2 reset = 1'b1;
      push_pkt(1, 1, 32'h510);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      wait_log(7, 40, "s5");
      chk_beat("s5_pre0", 1, 3, 32'h530);
      chk_beat("s5_pre1", 2, 3, 32'h531);
      chk_beat("s5_ptr0_first", 3, 1, 32'h510);
      for (int i = 2; i < 5; i++) chk_beat("s5_src3_rest", i + 2, 3, D'(32'h530 + i));
      repeat (5) @(posedge clk);
      chk("s5_count", 64'(xlog.size()), 64'd7);

      // Alternating single-beat packets from src0 and src3.
      do_reset();
      for (int r = 0; r < 3; r++) begin
         push_pkt(0, 1, D'(32'h600 + r));
         push_pkt(3, 1, D'(32'h630 + r));
      end
      wait_log(6, 40, "s6");
      for (int r = 0; r < 3; r++) begin
         chk_beat("s6_src0", 2 * r, 0, D'(32'h600 + r));
         chk_beat("s6_src3", 2 * r + 1, 3, D'(32'h630 + r));
      end
      for (int k = 1; k < 6; k++) chk_gap("s6_gap", k, 2);

      // Randomized traffic, valid gaps, backpressure and occasional resets.
      do_reset();
      rnd = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() < 6 && $urandom_range(7) == 0)
               push_pkt(i, $urandom_range(4, 1), D'($urandom));
         end
         if ($urandom_range(499) == 0) begin
            #2 reset = 1'b1;
            @(posedge clk);
            #2 reset = 1'b0;
         end
      end
      rnd = 1'b0;
      drained = 0;
      for (int t = 0; t < 500 && !drained; t++) begin
         @(posedge clk);
         drained = 1;
         for (int i = 0; i < N; i++) if (src_q[i].size() != 0) drained = 0;
      end
      chk("rnd_drained", 64'(drained), 64'd1);
      repeat (3) @(posedge clk);
      chk("rnd_idle_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
